// File: rtl/sync_fifo_rd_prefetch.sv
// ---------------------------------------------------------------------------
// sync_fifo_rd_prefetch
//
// Read stage for a pointer-based synchronous FIFO. The FIFO returns each
// word one cycle after its read strobe. This block keeps up to two words
// in a small output buffer and presents them on a valid/ready stream. That
// hides the read latency and allows one beat per clock when the consumer
// is always ready. Accepted beats are counted for debug.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active high
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO read data; valid the cycle after an accepted read
//   fifo_rd_en  FIFO read strobe (combinational, also depends on m_ready)
//   m_valid     stream valid (registered)
//   m_data      stream data, head of buffer (registered)
//   m_ready     stream ready from the consumer
//   occupancy   number of buffered words, 0..2
//   beat_cnt    accepted beats (m_valid & m_ready), wraps around
// ---------------------------------------------------------------------------
module sync_fifo_rd_prefetch #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [1:0]            occupancy,
  output logic [CNT_WIDTH-1:0]  beat_cnt
);

  localparam int DEPTH = 2;

  // Control state
  logic [1:0]           r_occ;
  logic                 r_inflight;
  logic [CNT_WIDTH-1:0] r_beat_cnt;

  // Derived control
  logic       w_pop;
  logic [1:0] w_occ_after_pop;
  logic [2:0] w_committed;
  logic [1:0] w_occ_next;

  // The consumer can only take a word that is actually presented.
  assign w_pop = (r_occ != 2'd0) & m_ready;

  // Buffer level once this cycle's pop is taken out; w_pop implies r_occ > 0.
  assign w_occ_after_pop = r_occ - {1'b0, w_pop};

  // Slots already committed for the next cycle: words held after the pop,
  // plus the word that is still on its way from the FIFO.
  assign w_committed = {1'b0, w_occ_after_pop} + {2'b00, r_inflight};

  // A new read is issued only if its word is certain to have a free slot.
  // m_ready feeds this strobe combinationally, so the buffer refills in the
  // same cycle a beat leaves. That keeps a full-rate stream with only two
  // entries.
  assign fifo_rd_en = ~rst & ~fifo_empty & (w_committed < 3'd2);

  // Reads are only issued while w_committed < 2. So w_committed never goes
  // above 2, and the low two bits hold the complete next level.
  assign w_occ_next = w_committed[1:0];

  // -------------------------------------------------------------------------
  // Output buffer, one register per slot. Slot 0 is the head.
  // On a pop every slot takes the value of the slot behind it. A word coming
  // back from the FIFO is written into the first free slot after that shift.
  // This keeps the head the oldest word at all times.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      localparam logic [1:0] SLOT_IDX = 2'(gi);

      logic [DATA_WIDTH-1:0] r_data;
      logic [DATA_WIDTH-1:0] w_shift_src;
      logic [DATA_WIDTH-1:0] w_data_next;
      logic                  w_capture_here;

      assign w_capture_here = r_inflight & (w_occ_after_pop == SLOT_IDX);

      if (gi < DEPTH - 1) begin : g_shift
        assign w_shift_src = w_pop ? g_slot[gi+1].r_data : r_data;
      end else begin : g_tail
        // The tail has nothing behind it. After a pop its old contents are
        // stale but unused, because occupancy bounds what is valid.
        assign w_shift_src = r_data;
      end

      assign w_data_next = w_capture_here ? fifo_data : w_shift_src;

      // Data slots have no reset. Their contents only matter where
      // occupancy says they are valid.
      always_ff @(posedge clk) begin
        r_data <= w_data_next;
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;   // any word returning from the FIFO is dropped
      r_beat_cnt <= '0;
    end else begin
      r_occ      <= w_occ_next;
      r_inflight <= fifo_rd_en;
      if (w_pop) begin
        r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // The head register changes only on a pop, or when a word is captured
  // into an empty head. So m_data stays stable while a beat is stalled.
  assign m_valid   = (r_occ != 2'd0);
  assign m_data    = g_slot[0].r_data;
  assign occupancy = r_occ;
  assign beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_sync_fifo_rd_prefetch.sv
// ---------------------------------------------------------------------------
// Bench for sync_fifo_rd_prefetch.
// A behavioural FIFO model feeds the DUT. Every word written into the model
// is also pushed into an expected-data queue. A monitor process pops that
// queue on each accepted beat and compares. It also checks the stall-hold
// rule and the occupancy bound. The main process drives directed scenarios
// and checks flags and counters at fixed points.
// ---------------------------------------------------------------------------
module tb_sync_fifo_rd_prefetch;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data  = '0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready    = 1'b0;
  logic [1:0]    occupancy;
  logic [CW-1:0] beat_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fifo_q[$];   // FIFO model storage
  logic [DW-1:0] load_q[$];   // words written into the model on the next edge
  logic [DW-1:0] exp_q[$];    // scoreboard: expected beats in order

  always #5 clk = ~clk;

  sync_fifo_rd_prefetch #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .occupancy (occupancy),
    .beat_cnt  (beat_cnt)
  );

  // FIFO model: writes and reads land on the clock edge, read data is
  // registered, and the empty flag is registered. It resets with the DUT.
  always @(posedge clk) begin
    if (rst) begin
      fifo_q.delete();
      load_q.delete();
    end else begin
      if (fifo_rd_en && !fifo_empty) begin
        fifo_data <= fifo_q.pop_front();
      end
      while (load_q.size() > 0) begin
        fifo_q.push_back(load_q.pop_front());
      end
    end
    fifo_empty <= rst ? 1'b1 : (fifo_q.size() == 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [DW-1:0] v);
    load_q.push_back(v);
    exp_q.push_back(v);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    @(negedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  // Monitor: scoreboard compare on accepted beats, plus the hold rule.
  logic          mon_prev_stall = 1'b0;
  logic [DW-1:0] mon_prev_data  = '0;
  always @(negedge clk) begin
    if (mon_prev_stall) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_data", m_data, mon_prev_data);
    end
    if (occupancy > 2'd2) begin
      chk("occ_bound", occupancy, 2);
    end
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat_data: got 0x%0h, expected no beat at %0t", m_data, $time);
      end else begin
        chk("beat_data", m_data, exp_q.pop_front());
      end
      $display("beat 0x%02h cnt_before=%0d", m_data, beat_cnt);
    end
    mon_prev_stall = !rst && m_valid && !m_ready;
    mon_prev_data  = m_data;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rd_cnt;
    int gaps;
    int sent;
    int n;
    bit found;

    // --- Reset, then idle with the FIFO empty ---
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_rd_en", fifo_rd_en, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_rd_en", fifo_rd_en, 0);
      chk("idle_valid", m_valid, 0);
      chk("idle_occ", occupancy, 0);
      chk("idle_beat", beat_cnt, 0);
      tick();
    end

    // --- Single word 0xAA, consumer ready ---
    m_ready = 1'b1;
    load(8'hAA);
    tick();                          // empty falls: cycle N
    @(negedge clk);
    chk("aa_rd_en_N", fifo_rd_en, 1);
    chk("aa_valid_N", m_valid, 0);
    tick();                          // N+1
    @(negedge clk);
    chk("aa_rd_en_N1", fifo_rd_en, 0);
    chk("aa_valid_N1", m_valid, 0);
    tick();                          // N+2
    @(negedge clk);
    chk("aa_valid_N2", m_valid, 1);
    chk("aa_data_N2", m_data, 8'hAA);
    tick();                          // N+3
    @(negedge clk);
    chk("aa_occ", occupancy, 0);
    chk("aa_beat", beat_cnt, 1);

    // --- 16 words, consumer always ready: no gaps ---
    tick();
    for (int i = 0; i < 16; i++) load(8'(i));
    found = 1'b0;
    n = 0;
    while (!found && n < 20) begin
      tick();
      @(negedge clk);
      found = m_valid;
      n++;
    end
    chk("burst_first_valid", found, 1);
    gaps = 0;
    for (int i = 0; i < 16; i++) begin
      if (!m_valid) gaps++;
      tick();
      @(negedge clk);
    end
    chk("burst_gaps", gaps, 0);
    chk("burst_beat", beat_cnt, 17);
    chk("burst_done_valid", m_valid, 0);
    chk("burst_rd_en_idle", fifo_rd_en, 0);
    chk("burst_sb_empty", exp_q.size(), 0);

    // --- 8 words, consumer stalled: exactly two prefetched ---
    m_ready = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) load(8'h10 + 8'(i));
    rd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      @(negedge clk);
      if (fifo_rd_en) rd_cnt++;
    end
    chk("stall_reads", rd_cnt, 2);
    chk("stall_occ", occupancy, 2);
    chk("stall_valid", m_valid, 1);
    chk("stall_data", m_data, 8'h10);
    // Toggle ready every cycle until everything has been delivered.
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      m_ready = ~m_ready;
      n++;
    end
    m_ready = 1'b0;
    tick();
    @(negedge clk);
    chk("toggle_sb_empty", exp_q.size(), 0);
    chk("toggle_beat", beat_cnt, 25);
    chk("toggle_occ", occupancy, 0);

    // --- 200 words with random writes and random ready ---
    sent = 0;
    n = 0;
    while ((sent < 200 || exp_q.size() != 0) && n < 4000) begin
      tick();
      m_ready = 1'($urandom_range(0, 1));
      if (sent < 200 && $urandom_range(0, 1) == 1) begin
        load(8'(sent * 37 + 5));
        sent++;
      end
      n++;
    end
    m_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rand_sent", sent, 200);
    chk("rand_sb_empty", exp_q.size(), 0);
    chk("rand_beat", beat_cnt, 225);

    // --- Reset mid-operation: head valid and a read in flight ---
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) load(8'h20 + 8'(i));
    tick();                          // cycle N: first read
    tick();                          // N+1: second read, one in flight
    @(negedge clk);
    chk("pre_rst_valid", m_valid, 0);
    tick();                          // N+2: occ=1, inflight=1, FIFO not empty
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_rd_en", fifo_rd_en, 0);
    chk("mid_rst_occ_before", occupancy, 1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", m_valid, 0);
    chk("post_rst_occ", occupancy, 0);
    chk("post_rst_beat", beat_cnt, 0);
    chk("post_rst_rd_en", fifo_rd_en, 0);
    tick();
    load(8'h55);
    drain("post_rst_drain", 20);
    chk("post_rst_beat_one", beat_cnt, 1);
    chk("post_rst_occ_end", occupancy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
